// File: rtl/hedios_rx_packet_assembler.sv
// Hedios RX packet assembler: frames UART bytes into cmd + 4 data bytes and queues packets in a FIFO.
// Define HEDIOS_RX_CHECKSUM_EN to require a trailing XOR checksum byte after each packet.
module hedios_rx_packet_assembler #(
    parameter int DEPTH          = 8,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int COUNT_W        = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         byte_in,
    input  logic               byte_valid,
    input  logic               rx_pop_packet,
    input  logic               rx_lost_clear,
    output logic [7:0]         rx_command,
    output logic [31:0]        rx_data,
    output logic               rx_empty,
    output logic               rx_full,
    output logic               rx_lost_data,
    output logic               rx_frame_error,
    output logic [COUNT_W-1:0] rx_count
);
    localparam int PTR_W      = $clog2(DEPTH);
    localparam int GAP_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

`ifdef HEDIOS_RX_CHECKSUM_EN
    typedef enum logic [1:0] {WAIT_CMD, WAIT_DATA, CHECK, COMMIT} state_t;
`else
    typedef enum logic [1:0] {WAIT_CMD, WAIT_DATA, COMMIT} state_t;
`endif

    state_t             state_q, state_d;
    logic [1:0]         byte_idx_q;
    logic [GAP_W-1:0]   gap_q;
    logic [7:0]         cmd_p0;
    logic [31:0]        data_p0;
    logic               latch_cmd, latch_data, vld_p0, frame_err_d;
    logic               in_packet, expire;
    logic [39:0]        mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic               do_wr, do_pop;
    logic [COUNT_W-1:0] count_d;

`ifdef HEDIOS_RX_CHECKSUM_EN
    function automatic logic [7:0] checksum(input logic [7:0] cmd, input logic [31:0] data);
        return cmd ^ data[7:0] ^ data[15:8] ^ data[23:16] ^ data[31:24];
    endfunction

    assign in_packet = (state_q == WAIT_DATA) || (state_q == CHECK);
`else
    assign in_packet = (state_q == WAIT_DATA);
`endif

    assign expire = TIMEOUT_EN && in_packet && (gap_q == GAP_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk) begin
        if (rst) state_q <= WAIT_CMD;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        latch_cmd   = 1'b0;
        latch_data  = 1'b0;
        vld_p0      = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            WAIT_CMD: begin
                if (byte_valid) begin
                    latch_cmd = 1'b1;
                    state_d   = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                if (byte_valid) begin
                    latch_data = 1'b1;
`ifdef HEDIOS_RX_CHECKSUM_EN
                    if (byte_idx_q == 2'd3) state_d = CHECK;
`else
                    if (byte_idx_q == 2'd3) state_d = COMMIT;
`endif
                end
            end
`ifdef HEDIOS_RX_CHECKSUM_EN
            CHECK: begin
                if (byte_valid) begin
                    if (byte_in == checksum(cmd_p0, data_p0)) begin
                        state_d = COMMIT;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = WAIT_CMD;
                    end
                end
            end
`endif
            COMMIT: begin
                vld_p0 = 1'b1;
                // A byte landing here starts the next packet immediately.
                latch_cmd = byte_valid;
                state_d   = byte_valid ? WAIT_DATA : WAIT_CMD;
            end
            default: state_d = WAIT_CMD;
        endcase
        // Timeout overrides whatever the partial packet was doing; a coincident byte is a new command.
        if (expire) begin
            frame_err_d = 1'b1;
            latch_data  = 1'b0;
            latch_cmd   = byte_valid;
            state_d     = byte_valid ? WAIT_DATA : WAIT_CMD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || byte_valid || !in_packet) gap_q <= '0;
        else if (TIMEOUT_EN)                 gap_q <= gap_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)             byte_idx_q <= 2'd0;
        else if (latch_cmd)  byte_idx_q <= 2'd0;
        else if (latch_data) byte_idx_q <= byte_idx_q + 2'd1;
    end

    // Stage p0: packet assembly registers
    always_ff @(posedge clk) begin
        if (latch_cmd)  cmd_p0 <= byte_in;
        if (latch_data) data_p0[8*byte_idx_q +: 8] <= byte_in;
    end

    assign do_pop = rx_pop_packet && !rx_empty;
    assign do_wr  = vld_p0 && (!rx_full || do_pop);

    always_comb begin
        count_d = rx_count;
        if (do_wr && !do_pop)      count_d = rx_count + 1'b1;
        else if (!do_wr && do_pop) count_d = rx_count - 1'b1;
    end

    // Stage p1: packet FIFO and registered consumer outputs
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr_q] <= {cmd_p0, data_p0};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            rx_count       <= '0;
            rx_empty       <= 1'b1;
            rx_full        <= 1'b0;
            rx_lost_data   <= 1'b0;
            rx_frame_error <= 1'b0;
            rx_command     <= '0;
            rx_data        <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop) begin
                rd_ptr_q                <= rd_ptr_q + 1'b1;
                {rx_command, rx_data}   <= mem[rd_ptr_q];
            end
            rx_count       <= count_d;
            rx_empty       <= (count_d == '0);
            rx_full        <= (count_d == COUNT_W'(DEPTH));
            rx_frame_error <= frame_err_d;
            if (vld_p0 && !do_wr) rx_lost_data <= 1'b1;
            else if (rx_lost_clear) rx_lost_data <= 1'b0;
        end
    end
endmodule
